// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_responder
//  Purpose  : Target side of the request-unit RAM handshake. Accepts one word
//             read or write at a time, holds busy for a programmable wait,
//             then completes the access with range checking. Out-of-range
//             accesses raise error for the completing cycle. Writes to them
//             are dropped, and reads to them return 32'hBAD1_BAD1.
//  Ports    : clk          - system clock, rising edge
//             nRst         - asynchronous active-low reset
//             read_enable  - read request, held until busy low
//             write_enable - write request, held until busy low (wins over read)
//             addr         - byte address, bits [1:0] ignored
//             data_in      - write data
//             data_out     - read data, valid in the cycle busy is low after a read
//             busy         - combinational, 1 while a request is not complete
//             error        - 1 in the completing cycle of an out-of-range access
//  Revision : 1.0 - initial release
// ============================================================================
module ram_responder #(
   parameter int          DEPTH     = 256,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        error
);

   localparam int          IDXW     = $clog2(DEPTH);
   localparam int          CW       = $clog2(LATENCY + 1);
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [31:0] OOR_DATA = 32'hBAD1_BAD1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_q, wr_d;       // latched op: 1 = write
   logic            rd_q, rd_d;       // read also requested (both-enables case reads old data)
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic [31:0]     data_out_q, data_out_d;
   logic [31:0]     mem_q [DEPTH];

   logic            req;
   logic [31:0]     offset;
   logic            in_range;
   logic [IDXW-1:0] idx;
   logic [31:0]     rd_word;
   logic            commit;

   assign req      = read_enable | write_enable;
   // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap to huge
   // offsets, but the explicit >= test keeps them out of range regardless.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
   assign idx      = offset[IDXW+1:2];
   assign rd_word  = in_range ? mem_q[idx] : OOR_DATA;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      data_out_d = data_out_q;
      data_out   = data_out_q;
      busy       = 1'b0;
      error      = 1'b0;
      commit     = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = req;
            if (req) begin
               wr_d    = write_enable;
               rd_d    = read_enable;
               addr_d  = addr;
               data_d  = data_in;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!req) begin
               // Initiator withdrew: drop the access without side effects.
               state_d = S_IDLE;
            end else if (cnt_q != '0) begin
               busy  = 1'b1;
               cnt_d = cnt_q - CW'(1);
            end else begin
               // Completing cycle.
               error   = ~in_range;
               commit  = wr_q & in_range;
               state_d = S_IDLE;
               if (rd_q) begin
                  data_out   = rd_word;
                  data_out_d = rd_word;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         data_out_q <= data_out_d;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         mem_q[idx] <= data_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_responder
//  Purpose  : Self-checking bench for ram_responder. Two instances share the
//             clock and reset: u_dut0 uses DEPTH=16, LATENCY=2, BASE_ADDR=0,
//             and u_dut1 uses DEPTH=16, LATENCY=1, BASE_ADDR=0x100. Expected
//             completions come from a memory model and are queued when the
//             stimulus is driven. They are popped when busy drops.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

   localparam logic [31:0] BAD = 32'hBAD1_BAD1;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0;
   logic [31:0] dout0, dout1;
   logic        busy0, busy1, err0, err1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] dout;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mdl [2][16];   // reference memory per instance
   logic [31:0] mdo [2];       // reference held data_out per instance

   always #5 clk = ~clk;

   ram_responder #(.DEPTH(16), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut0 (
      .clk(clk), .nRst(nRst), .read_enable(re0), .write_enable(we0),
      .addr(addr0), .data_in(din0), .data_out(dout0), .busy(busy0), .error(err0));

   ram_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h100)) u_dut1 (
      .clk(clk), .nRst(nRst), .read_enable(re1), .write_enable(we1),
      .addr(addr1), .data_in(din1), .data_out(dout1), .busy(busy1), .error(err1));

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit sel, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d);
      if (sel) begin we1 = w; re1 = r; addr1 = a; din1 = d; end
      else     begin we0 = w; re0 = r; addr0 = a; din0 = d; end
   endtask

   function automatic logic get_busy(input bit sel);
      return sel ? busy1 : busy0;
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 2; s++) begin
         mdo[s] = '0;
         for (int i = 0; i < 16; i++) mdl[s][i] = '0;
      end
   endtask

   // One complete access: queue the expectation, drive, wait for busy low
   // (bounded), then compare latency, data_out and error.
   task automatic access(input bit sel, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
      exp_t        e;
      exp_t        got;
      logic [31:0] base;
      logic [31:0] off;
      logic        ok;
      int          idx;
      int          cyc;
      base  = sel ? 32'h100 : 32'h0;
      off   = a - base;
      ok    = (a >= base) && (off < 32'd64);
      idx   = int'(off[5:2]);
      e.err = ~ok;
      e.lat = sel ? 1 : 2;
      if (r) begin
         e.dout   = ok ? mdl[sel][idx] : BAD;
         mdo[sel] = e.dout;
      end else begin
         e.dout = mdo[sel];
      end
      if (w && ok) mdl[sel][idx] = d;
      sb.push_back(e);

      @(posedge clk); #1;
      set_req(sel, w, r, a, d);
      cyc = 0;
      @(negedge clk);
      while (get_busy(sel) === 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      got = sb.pop_front();
      chk({tag, "_lat"}, 32'(cyc), 32'(got.lat));
      chk({tag, "_dout"}, sel ? dout1 : dout0, got.dout);
      chk({tag, "_err"}, {31'd0, sel ? err1 : err0}, {31'd0, got.err});
      @(posedge clk); #1;
      set_req(sel, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      clear_model();

      // Reset state
      @(negedge clk);
      chk("rst_busy0", {31'd0, busy0}, 32'd0);
      chk("rst_err0",  {31'd0, err0},  32'd0);
      chk("rst_dout0", dout0, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_dout1", dout1, 32'd0);
      @(posedge clk); #1;
      nRst = 1'b1;

      // 1: basic write then read, LATENCY=2
      access(0, 1, 0, 32'h10, 32'hDEAD_BEEF, "t1_wr");
      access(0, 0, 1, 32'h10, 32'h0, "t1_rd");

      // 2: low address bits ignored, range boundaries
      access(0, 1, 0, 32'h13, 32'h1234_5678, "t2_wr13");
      access(0, 0, 1, 32'h10, 32'h0, "t2_rd10");
      access(0, 0, 1, 32'h3C, 32'h0, "t2_rd_last");
      access(0, 0, 1, 32'h40, 32'h0, "t2_rd_oor");
      access(0, 1, 0, 32'h40, 32'hFFFF_FFFF, "t2_wr_oor");
      access(0, 0, 1, 32'h00, 32'h0, "t2_rd_alias");

      // 3: back-to-back writes with write_enable held; address change in WAIT ignored
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h20, 32'hAAAA_0001);
      @(negedge clk); chk("t3_busy_c0", {31'd0, busy0}, 32'd1);
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h24, 32'hBBBB_0002);
      @(negedge clk); chk("t3_busy_c1", {31'd0, busy0}, 32'd1);
      for (int c = 2; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("t3_busy_c%0d", c), {31'd0, busy0}, (c == 2 || c == 5) ? 32'd0 : 32'd1);
         chk($sformatf("t3_err_c%0d", c), {31'd0, err0}, 32'd0);
      end
      @(posedge clk); #1;
      set_req(0, 0, 0, 32'h0, 32'h0);
      mdl[0][8] = 32'hAAAA_0001;
      mdl[0][9] = 32'hBBBB_0002;
      access(0, 0, 1, 32'h20, 32'h0, "t3_rd20");
      access(0, 0, 1, 32'h24, 32'h0, "t3_rd24");

      // 4: abort in WAIT
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h8, 32'h1);
      @(negedge clk); chk("t4_busy_c0", {31'd0, busy0}, 32'd1);
      @(posedge clk); #1;
      set_req(0, 0, 0, 32'h8, 32'h1);
      @(negedge clk);
      chk("t4_busy_c1", {31'd0, busy0}, 32'd0);
      chk("t4_err_c1",  {31'd0, err0},  32'd0);
      chk("t4_dout_c1", dout0, mdo[0]);
      access(0, 0, 1, 32'h8, 32'h0, "t4_rd8");

      // 5: both enables -> write wins, data_out shows old contents
      access(0, 1, 0, 32'h4, 32'h3, "t5_wr3");
      access(0, 1, 1, 32'h4, 32'h7, "t5_both");
      access(0, 0, 1, 32'h4, 32'h0, "t5_rd7");

      // LATENCY=1 instance with a non-zero base
      access(1, 1, 0, 32'h104, 32'hA5A5_5A5A, "l1_wr");
      access(1, 0, 1, 32'h104, 32'h0, "l1_rd");
      access(1, 0, 1, 32'h0FC, 32'h0, "l1_below");
      access(1, 0, 1, 32'h13C, 32'h0, "l1_last");
      access(1, 1, 0, 32'h140, 32'h1, "l1_wr_oor");

      // 6: reset in the middle of writes on both instances
      @(posedge clk); #1;
      set_req(0, 1, 0, 32'h30, 32'h5555_5555);
      set_req(1, 1, 0, 32'h130, 32'h6666_6666);
      @(negedge clk);
      chk("t6_busy0_c0", {31'd0, busy0}, 32'd1);
      chk("t6_busy1_c0", {31'd0, busy1}, 32'd1);
      @(posedge clk); #1;
      nRst = 1'b0;
      @(negedge clk);
      chk("t6_busy0_rst", {31'd0, busy0}, 32'd1);
      chk("t6_busy1_rst", {31'd0, busy1}, 32'd1);
      chk("t6_dout0_rst", dout0, 32'd0);
      chk("t6_dout1_rst", dout1, 32'd0);
      chk("t6_err1_rst",  {31'd0, err1}, 32'd0);
      @(posedge clk); #1;
      set_req(0, 0, 0, 32'h0, 32'h0);
      set_req(1, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk("t6_busy0_idle", {31'd0, busy0}, 32'd0);
      @(posedge clk); #1;
      nRst = 1'b1;
      clear_model();
      for (int i = 0; i < 16; i++) begin
         access(0, 0, 1, 32'(i * 4), 32'h0, $sformatf("t6_mem0_%0d", i));
         access(1, 0, 1, 32'h100 + 32'(i * 4), 32'h0, $sformatf("t6_mem1_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
